// File: rtl/ddr3_cmd_decoder.sv
// DDR3 command-bus receiver for the PHY model: decodes each sampled command,
// tracks per-bank row state, enforces inter-command timing, returns reads
// after CL cycles and reports/counts protocol violations.
module ddr3_cmd_decoder #(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_RAS = 15,
  parameter int T_RFC = 44,
  parameter int T_CCD = 4,
  parameter int CL    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ddr3_ras_n,
  input  logic        ddr3_cas_n,
  input  logic        ddr3_we_n,
  input  logic [1:0]  ddr3_ba,
  input  logic [12:0] ddr3_addr,
  output logic [3:0]  bank_open,
  output logic [51:0] bank_row,
  output logic        rd_valid,
  output logic [1:0]  rd_bank,
  output logic [12:0] rd_col,
  output logic        wr_valid,
  output logic [1:0]  wr_bank,
  output logic [12:0] wr_col,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [1:0]  err_bank,
  output logic [15:0] err_count
);
  localparam int CW = 16;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING} bank_state_t;

  // Timers hold "cycles still to wait"; zero means the constraint is met.
  bank_state_t   state     [4];
  logic [CW-1:0] phase_cnt [4];
  logic [CW-1:0] ras_cnt   [4];
  logic [12:0]   row       [4];
  logic [CW-1:0] rfc_cnt;
  logic [CW-1:0] ccd_cnt;

  logic          rd_vld_p  [CL];
  logic [1:0]    rd_bank_p [CL];
  logic [12:0]   rd_col_p  [CL];

  logic [2:0]  cmd;
  logic        is_nop, is_act, is_rd, is_wr, is_pre, is_ref, is_ill;
  logic        refreshing, any_busy, err_hit;
  logic        acc_act, acc_rd, acc_wr, acc_pre, acc_ref;
  logic [2:0]  err_c;
  bank_state_t sel_state;

  assign cmd        = {ddr3_ras_n, ddr3_cas_n, ddr3_we_n};
  assign sel_state  = state[ddr3_ba];
  assign refreshing = (rfc_cnt != '0);

  // Command decode and "any bank not idle" summary.
  always_comb begin
    is_nop   = (cmd == 3'b111);
    is_act   = (cmd == 3'b011);
    is_rd    = (cmd == 3'b101);
    is_wr    = (cmd == 3'b100);
    is_pre   = (cmd == 3'b010);
    is_ref   = (cmd == 3'b001);
    is_ill   = (cmd == 3'b000) || (cmd == 3'b110);
    any_busy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (state[b] != S_IDLE) any_busy = 1'b1;
    end
  end

  // Violation check in priority order; an offending command is otherwise ignored.
  always_comb begin
    err_c = 3'd0;
    if (!is_nop && refreshing)
      err_c = 3'd5;
    else if (is_ill)
      err_c = 3'd6;
    else if (is_act && sel_state != S_IDLE)
      err_c = 3'd1;
    else if ((is_rd || is_wr) && sel_state != S_ACTIVE)
      err_c = 3'd2;
    else if ((is_rd || is_wr) && ccd_cnt != '0)
      err_c = 3'd7;
    else if (is_pre && (sel_state == S_ACTIVE || sel_state == S_ACTIVATING) && ras_cnt[ddr3_ba] != '0)
      err_c = 3'd3;
    else if (is_ref && any_busy)
      err_c = 3'd4;
    err_hit = (err_c != 3'd0);
    acc_act = is_act && !err_hit;
    acc_rd  = is_rd  && !err_hit;
    acc_wr  = is_wr  && !err_hit;
    acc_pre = is_pre && !err_hit;
    acc_ref = is_ref && !err_hit;
  end

  // Per-bank state machines with their tRCD/tRP phase timers and tRAS timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        state[b]     <= S_IDLE;
        phase_cnt[b] <= '0;
        ras_cnt[b]   <= '0;
        row[b]       <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ras_cnt[b] != '0) ras_cnt[b] <= ras_cnt[b] - ONE;
        case (state[b])
          S_IDLE: begin
            if (acc_act && ddr3_ba == 2'(b)) begin
              row[b]     <= ddr3_addr;
              ras_cnt[b] <= CW'(T_RAS - 1);
              if (T_RCD <= 1) begin
                state[b] <= S_ACTIVE;
              end else begin
                state[b]     <= S_ACTIVATING;
                phase_cnt[b] <= CW'(T_RCD - 2);
              end
            end
          end
          S_ACTIVATING, S_ACTIVE: begin
            if (acc_pre && ddr3_ba == 2'(b)) begin
              if (T_RP <= 1) begin
                state[b] <= S_IDLE;
              end else begin
                state[b]     <= S_PRECHARGING;
                phase_cnt[b] <= CW'(T_RP - 2);
              end
            end else if (state[b] == S_ACTIVATING) begin
              if (phase_cnt[b] == '0) state[b] <= S_ACTIVE;
              else phase_cnt[b] <= phase_cnt[b] - ONE;
            end
          end
          default: begin
            if (phase_cnt[b] == '0) state[b] <= S_IDLE;
            else phase_cnt[b] <= phase_cnt[b] - ONE;
          end
        endcase
      end
    end
  end

  // Global refresh and column-to-column spacing timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfc_cnt <= '0;
      ccd_cnt <= '0;
    end else begin
      if (acc_ref) rfc_cnt <= CW'(T_RFC - 1);
      else if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - ONE;
      if (acc_rd || acc_wr) ccd_cnt <= CW'(T_CCD - 1);
      else if (ccd_cnt != '0) ccd_cnt <= ccd_cnt - ONE;
    end
  end

  // CL-deep read-return pipeline; it keeps shifting through REF and PRE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CL; i++) begin
        rd_vld_p[i]  <= 1'b0;
        rd_bank_p[i] <= '0;
        rd_col_p[i]  <= '0;
      end
    end else begin
      rd_vld_p[0]  <= acc_rd;
      rd_bank_p[0] <= ddr3_ba;
      rd_col_p[0]  <= ddr3_addr;
      for (int i = 1; i < CL; i++) begin
        rd_vld_p[i]  <= rd_vld_p[i-1];
        rd_bank_p[i] <= rd_bank_p[i-1];
        rd_col_p[i]  <= rd_col_p[i-1];
      end
    end
  end

  // Registered write strobe, error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid  <= 1'b0;
      wr_bank   <= '0;
      wr_col    <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_bank  <= '0;
      err_count <= '0;
    end else begin
      wr_valid <= acc_wr;
      if (acc_wr) begin
        wr_bank <= ddr3_ba;
        wr_col  <= ddr3_addr;
      end
      err_valid <= err_hit;
      err_code  <= err_c;
      err_bank  <= err_hit ? ddr3_ba : 2'd0;
      if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  assign rd_valid = rd_vld_p[CL-1];
  assign rd_bank  = rd_bank_p[CL-1];
  assign rd_col   = rd_col_p[CL-1];

  // Bank status outputs straight from the state and row registers.
  always_comb begin
    bank_open = '0;
    bank_row  = '0;
    for (int b = 0; b < 4; b++) begin
      bank_open[b]        = (state[b] == S_ACTIVE);
      bank_row[13*b +: 13] = row[b];
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Scoreboard bench for ddr3_cmd_decoder: a timestamp-based reference model
// predicts every strobe, error and status value; a negedge monitor checks them.
module tb_ddr3_cmd_decoder;
  localparam int T_RCD = 5;
  localparam int T_RP  = 5;
  localparam int T_RAS = 15;
  localparam int T_RFC = 44;
  localparam int T_CCD = 4;
  localparam int CL    = 5;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001, C_ILL0 = 3'b000, C_ILL6 = 3'b110;
  localparam longint NEVER = -64'sd1000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ddr3_ras_n = 1'b1, ddr3_cas_n = 1'b1, ddr3_we_n = 1'b1;
  logic [1:0]  ddr3_ba = '0;
  logic [12:0] ddr3_addr = '0;
  logic [3:0]  bank_open;
  logic [51:0] bank_row;
  logic        rd_valid, wr_valid, err_valid;
  logic [1:0]  rd_bank, wr_bank, err_bank;
  logic [12:0] rd_col, wr_col;
  logic [2:0]  err_code;
  logic [15:0] err_count;

  ddr3_cmd_decoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC),
                     .T_CCD(T_CCD), .CL(CL)) dut (
    .clk(clk), .rst_n(rst_n), .ddr3_ras_n(ddr3_ras_n), .ddr3_cas_n(ddr3_cas_n),
    .ddr3_we_n(ddr3_we_n), .ddr3_ba(ddr3_ba), .ddr3_addr(ddr3_addr),
    .bank_open(bank_open), .bank_row(bank_row), .rd_valid(rd_valid), .rd_bank(rd_bank),
    .rd_col(rd_col), .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_col(wr_col),
    .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank), .err_count(err_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint due; logic [2:0] code; logic [1:0] bank; } err_t;
  typedef struct { longint due; logic [1:0] bank; logic [12:0] col; } xfer_t;
  typedef struct { longint due; logic [3:0] open; logic [51:0] row; int cnt; } stat_t;

  err_t  err_q  [$];
  xfer_t rd_q   [$];
  xfer_t wr_q   [$];
  stat_t stat_q [$];

  int compared = 0;
  int mismatched = 0;

  // Reference model: last accepted event times per bank plus open flag.
  longint      m_act [4];
  longint      m_pre [4];
  bit          m_open [4];
  logic [12:0] m_row [4];
  longint      m_ref, m_rw;
  int          m_cnt;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) begin
      m_act[b] = NEVER; m_pre[b] = NEVER; m_open[b] = 0; m_row[b] = '0;
    end
    m_ref = NEVER; m_rw = NEVER; m_cnt = 0;
    err_q.delete(); rd_q.delete(); wr_q.delete(); stat_q.delete();
  endfunction

  // 0 idle, 1 activating, 2 active, 3 precharging at cycle t
  function automatic int bstate(int b, longint t);
    if (m_open[b]) return (t >= m_act[b] + T_RCD) ? 2 : 1;
    return (t < m_pre[b] + T_RP) ? 3 : 0;
  endfunction

  function automatic void model_step(logic [2:0] c, logic [1:0] b, logic [12:0] a, longint t);
    int st, code;
    bit busy, rw;
    err_t e; xfer_t x; stat_t s;
    st = bstate(int'(b), t);
    busy = 0;
    for (int k = 0; k < 4; k++) if (bstate(k, t) != 0) busy = 1;
    rw = (c == C_RD) || (c == C_WR);
    code = 0;
    if (c != C_NOP && t < m_ref + T_RFC) code = 5;
    else if (c == C_ILL0 || c == C_ILL6) code = 6;
    else if (c == C_ACT && st != 0) code = 1;
    else if (rw && st != 2) code = 2;
    else if (rw && t < m_rw + T_CCD) code = 7;
    else if (c == C_PRE && (st == 1 || st == 2) && t < m_act[b] + T_RAS) code = 3;
    else if (c == C_REF && busy) code = 4;
    if (code != 0) begin
      e.due = t + 1; e.code = 3'(code); e.bank = b;
      err_q.push_back(e);
      if (m_cnt < 65535) m_cnt++;
    end else begin
      case (c)
        C_ACT: begin m_open[b] = 1; m_act[b] = t; m_row[b] = a; end
        C_RD:  begin x.due = t + CL; x.bank = b; x.col = a; rd_q.push_back(x); m_rw = t; end
        C_WR:  begin x.due = t + 1;  x.bank = b; x.col = a; wr_q.push_back(x); m_rw = t; end
        C_PRE: if (m_open[b]) begin m_open[b] = 0; m_pre[b] = t; end
        C_REF: m_ref = t;
        default: ;
      endcase
    end
    s.due = t + 1; s.cnt = m_cnt;
    for (int k = 0; k < 4; k++) begin
      s.open[k] = (bstate(k, t + 1) == 2);
      s.row[13*k +: 13] = m_row[k];
    end
    stat_q.push_back(s);
  endfunction

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    @(posedge clk); #1;
    {ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = c;
    ddr3_ba = b; ddr3_addr = a;
    model_step(c, b, a, cyc);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    {ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = C_NOP;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  err_t e_m; xfer_t x_m; stat_t s_m;

  // Monitor: pop and compare whenever the DUT presents a strobe; status every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      compared++;
      if (rd_valid || wr_valid || err_valid || bank_open != 4'h0 || err_count != 16'h0) begin
        mismatched++;
        $display("FAIL reset_outputs cyc=%0d rd=%0b wr=%0b err=%0b open=%h cnt=%0d (want all 0)",
                 cyc, rd_valid, wr_valid, err_valid, bank_open, err_count);
      end
    end else begin
      while (err_q.size() > 0 && err_q[0].due < cyc) begin
        compared++; mismatched++;
        $display("FAIL err_missing due=%0d code=%0d bank=%0d got none", err_q[0].due, err_q[0].code, err_q[0].bank);
        void'(err_q.pop_front());
      end
      if (err_valid) begin
        compared++;
        if (err_q.size() == 0 || err_q[0].due != cyc) begin
          mismatched++;
          $display("FAIL err_unexpected cyc=%0d got code=%0d bank=%0d want none", cyc, err_code, err_bank);
        end else begin
          e_m = err_q.pop_front();
          if (err_code != e_m.code || err_bank != e_m.bank) begin
            mismatched++;
            $display("FAIL err_value cyc=%0d got code=%0d bank=%0d want code=%0d bank=%0d",
                     cyc, err_code, err_bank, e_m.code, e_m.bank);
          end
        end
      end
      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        compared++; mismatched++;
        $display("FAIL rd_missing due=%0d bank=%0d col=%h got none", rd_q[0].due, rd_q[0].bank, rd_q[0].col);
        void'(rd_q.pop_front());
      end
      if (rd_valid) begin
        compared++;
        if (rd_q.size() == 0 || rd_q[0].due != cyc) begin
          mismatched++;
          $display("FAIL rd_unexpected cyc=%0d got bank=%0d col=%h want none", cyc, rd_bank, rd_col);
        end else begin
          x_m = rd_q.pop_front();
          if (rd_bank != x_m.bank || rd_col != x_m.col) begin
            mismatched++;
            $display("FAIL rd_value cyc=%0d got bank=%0d col=%h want bank=%0d col=%h",
                     cyc, rd_bank, rd_col, x_m.bank, x_m.col);
          end
        end
      end
      while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
        compared++; mismatched++;
        $display("FAIL wr_missing due=%0d bank=%0d col=%h got none", wr_q[0].due, wr_q[0].bank, wr_q[0].col);
        void'(wr_q.pop_front());
      end
      if (wr_valid) begin
        compared++;
        if (wr_q.size() == 0 || wr_q[0].due != cyc) begin
          mismatched++;
          $display("FAIL wr_unexpected cyc=%0d got bank=%0d col=%h want none", cyc, wr_bank, wr_col);
        end else begin
          x_m = wr_q.pop_front();
          if (wr_bank != x_m.bank || wr_col != x_m.col) begin
            mismatched++;
            $display("FAIL wr_value cyc=%0d got bank=%0d col=%h want bank=%0d col=%h",
                     cyc, wr_bank, wr_col, x_m.bank, x_m.col);
          end
        end
      end
      while (stat_q.size() > 0 && stat_q[0].due < cyc) void'(stat_q.pop_front());
      if (stat_q.size() > 0 && stat_q[0].due == cyc) begin
        s_m = stat_q.pop_front();
        compared++;
        if (bank_open != s_m.open || bank_row != s_m.row || int'(err_count) != s_m.cnt) begin
          mismatched++;
          $display("FAIL status cyc=%0d got open=%h row=%h cnt=%0d want open=%h row=%h cnt=%0d",
                   cyc, bank_open, bank_row, err_count, s_m.open, s_m.row, s_m.cnt);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ACT then READ once tRCD is met; read returns CL later
    do_reset();
    issue(C_ACT, 2'd1, 13'h0ABC); nop(4);
    issue(C_RD, 2'd1, 13'h010);   nop(7);

    // READ before tRCD
    do_reset();
    issue(C_ACT, 2'd1, 13'h0123); nop(2);
    issue(C_RD, 2'd1, 13'h020);   nop(7);

    // tRAS, tRP and ACT-to-busy-bank
    do_reset();
    issue(C_ACT, 2'd0, 13'h1111); nop(9);
    issue(C_PRE, 2'd0, 13'h0);    nop(4);
    issue(C_PRE, 2'd0, 13'h0);    nop(3);
    issue(C_ACT, 2'd0, 13'h0222);
    issue(C_ACT, 2'd0, 13'h0333); nop(3);

    // refresh window and REF with an open bank
    do_reset();
    issue(C_REF, 2'd0, 13'h0);    nop(42);
    issue(C_ACT, 2'd2, 13'h0444);
    issue(C_ACT, 2'd2, 13'h0555); nop(5);
    issue(C_REF, 2'd2, 13'h0);    nop(2);

    // tCCD across banks, illegal encodings
    do_reset();
    issue(C_ACT, 2'd0, 13'h0AAA);
    issue(C_ACT, 2'd3, 13'h0BBB); nop(8);
    issue(C_RD, 2'd0, 13'h005);   nop(1);
    issue(C_WR, 2'd3, 13'h006);   nop(1);
    issue(C_WR, 2'd3, 13'h007);
    issue(C_ILL0, 2'd2, 13'h0);
    issue(C_ILL6, 2'd1, 13'h0);   nop(6);

    // saturating error counter
    do_reset();
    for (int i = 0; i < 65540; i++) issue(C_ILL0, 2'(i), 13'h0);
    nop(2);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      issue(C_NOP, 2'($urandom), 13'($urandom));
      else if (r < 55) issue(C_ACT, 2'($urandom), 13'($urandom));
      else if (r < 70) issue(C_RD,  2'($urandom), 13'($urandom));
      else if (r < 80) issue(C_WR,  2'($urandom), 13'($urandom));
      else if (r < 92) issue(C_PRE, 2'($urandom), 13'($urandom));
      else if (r < 95) issue(C_REF, 2'($urandom), 13'($urandom));
      else if (r < 98) issue(C_ILL0, 2'($urandom), 13'($urandom));
      else             issue(C_ILL6, 2'($urandom), 13'($urandom));
    end
    nop(CL + 2);

    // reset with a read in flight discards it
    do_reset();
    issue(C_ACT, 2'd0, 13'h0777); nop(4);
    issue(C_RD, 2'd0, 13'h0FF);   nop(1);
    do_reset();
    nop(10);

    nop(CL + 2);
    compared++;
    if (err_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) begin
      mismatched++;
      $display("FAIL queues_drained got err=%0d rd=%0d wr=%0d pending want 0",
               err_q.size(), rd_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
